// File: rtl/neuron_datapath_pkg.sv
// Shared constants, types and arithmetic helpers for the neuron datapath.
package neuron_datapath_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned FRAC    = 8;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned INSTR_W = OPC_W + 2 * DATA_W;
  localparam int unsigned WIDE_W  = 2 * DATA_W + 2;
  localparam int unsigned CNT_W   = $clog2(DATA_W);

  localparam logic [DATA_W-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [DATA_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [DATA_W-1:0] SAT_MAX   = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN   = 16'h8000;

  localparam logic signed [WIDE_W-1:0] SAT_MAX_W = WIDE_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [WIDE_W-1:0] SAT_MIN_W = ~SAT_MAX_W;

  localparam logic signed [DATA_W+1:0] SIGM_BIAS_W = (DATA_W + 2)'(128);
  localparam logic signed [DATA_W+1:0] SIGM_MAX_W  = (DATA_W + 2)'(256);

  typedef enum logic [OPC_W-1:0] {
    OPC_NOP  = 4'd0,
    OPC_ADD  = 4'd1,
    OPC_SUB  = 4'd2,
    OPC_MUL  = 4'd3,
    OPC_MAC  = 4'd4,
    OPC_CLRA = 4'd5,
    OPC_RELU = 4'd6,
    OPC_SIGM = 4'd7,
    OPC_RAND = 4'd8,
    OPC_SEED = 4'd9,
    OPC_MUTE = 4'd10
  } opc_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MULT,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } instr_t;

  function automatic logic signed [WIDE_W-1:0] wide(input logic signed [DATA_W-1:0] x);
    return WIDE_W'(x);
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic signed [WIDE_W-1:0] x);
    if (x > SAT_MAX_W) return SAT_MAX;
    if (x < SAT_MIN_W) return SAT_MIN;
    return x[DATA_W-1:0];
  endfunction

  // Galois LFSR, right-shifting.
  function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] x);
    return (x >> 1) ^ (x[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/neuron_datapath_mult.sv
// Radix-2 shift-add signed multiplier: one multiplier bit per cycle, DATA_W cycles.
module seq_mult_signed
  import neuron_datapath_pkg::*;
(
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       start,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] product,
  output logic                       done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic signed [2*DATA_W-1:0] mcand_q, mcand_d;
  logic        [DATA_W-1:0]   mplier_q, mplier_d;
  logic signed [2*DATA_W-1:0] prod_q, prod_d;
  logic        [CNT_W-1:0]    cnt_q, cnt_d;
  logic                       run_q, run_d;
  logic                       done_q, done_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      done_q   <= done_d;
    end
  end

  // The sign bit of b carries weight -2^(DATA_W-1), so the last step subtracts.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    done_d   = 1'b0;
    if (start) begin
      mcand_d  = (2 * DATA_W)'(a);
      mplier_d = b;
      prod_d   = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) prod_d = (cnt_q == LAST) ? prod_q - mcand_q : prod_q + mcand_q;
      mcand_d  = mcand_q <<< 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign product = prod_q;
  assign done    = done_q;

endmodule

// File: rtl/neuron_datapath.sv
// Fixed-point execution unit: start-edge accept, single-cycle ALU or iterative multiply,
// registered result with a one-cycle finished pulse; owns the accumulator and LFSR.
module neuron_datapath
  import neuron_datapath_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               start,
  output logic [DATA_W-1:0]  result,
  output logic               finished,
  output logic               busy,
  output logic               illegal
);

  state_e                    state_q, state_d;
  logic                      start_q, start_d;
  logic [OPC_W-1:0]          opc_q, opc_d;
  logic signed [DATA_W-1:0]  a_q, a_d;
  logic signed [DATA_W-1:0]  b_q, b_d;
  logic signed [DATA_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]         lfsr_q, lfsr_d;
  logic [DATA_W-1:0]         result_q, result_d;
  logic                      finished_q, finished_d;
  logic                      busy_q, busy_d;
  logic                      illegal_q, illegal_d;

  instr_t                    instr_c;
  logic                      accept_c;
  logic                      is_mult_c;
  logic                      mult_start_c;
  logic signed [2*DATA_W-1:0] mult_prod;
  logic                      mult_done;

  logic [DATA_W-1:0]         alu_res_c;
  logic                      alu_ill_c;
  logic signed [DATA_W-1:0]  acc_nx_c;
  logic [DATA_W-1:0]         lfsr_nx_c;
  logic [DATA_W-1:0]         lfsr_step_c;
  logic [DATA_W-1:0]         mul_sat_c;
  logic signed [DATA_W-1:0]  mute_sh_c;
  logic signed [DATA_W+1:0]  sig_c;

  assign instr_c      = instr_t'(instruction);
  assign accept_c     = start && !start_q && (state_q == ST_IDLE);
  assign is_mult_c    = (instr_c.opc == OPC_MUL) || (instr_c.opc == OPC_MAC);
  assign mult_start_c = accept_c && is_mult_c;

  seq_mult_signed u_mult (
    .clock   (clock),
    .resetn  (resetn),
    .start   (mult_start_c),
    .a       (instr_c.a),
    .b       (instr_c.b),
    .product (mult_prod),
    .done    (mult_done)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      opc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      result_q   <= '0;
      finished_q <= 1'b0;
      busy_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      opc_q      <= opc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      lfsr_q     <= lfsr_d;
      result_q   <= result_d;
      finished_q <= finished_d;
      busy_q     <= busy_d;
      illegal_q  <= illegal_d;
    end
  end

  // Result and side-effect values for the latched instruction; consumed in DONE.
  always_comb begin
    alu_res_c   = '0;
    alu_ill_c   = 1'b0;
    acc_nx_c    = acc_q;
    lfsr_nx_c   = lfsr_q;
    lfsr_step_c = lfsr_step(lfsr_q);
    mul_sat_c   = sat(WIDE_W'(mult_prod >>> FRAC));
    mute_sh_c   = signed'(lfsr_step_c) >>> b_q[3:0];
    sig_c       = (DATA_W + 2)'(a_q >>> 2) + SIGM_BIAS_W;
    case (opc_q)
      OPC_NOP:  alu_res_c = '0;
      OPC_ADD:  alu_res_c = sat(wide(a_q) + wide(b_q));
      OPC_SUB:  alu_res_c = sat(wide(a_q) - wide(b_q));
      OPC_MUL:  alu_res_c = mul_sat_c;
      OPC_MAC: begin
        acc_nx_c  = sat(wide(acc_q) + wide(mul_sat_c));
        alu_res_c = acc_nx_c;
      end
      OPC_CLRA: begin
        acc_nx_c  = '0;
        alu_res_c = '0;
      end
      OPC_RELU: alu_res_c = a_q[DATA_W-1] ? '0 : a_q;
      OPC_SIGM: begin
        if (sig_c[DATA_W+1])        alu_res_c = '0;
        else if (sig_c > SIGM_MAX_W) alu_res_c = SIGM_MAX_W[DATA_W-1:0];
        else                        alu_res_c = sig_c[DATA_W-1:0];
      end
      OPC_RAND: begin
        lfsr_nx_c = lfsr_step_c;
        alu_res_c = lfsr_step_c;
      end
      OPC_SEED: begin
        lfsr_nx_c = (a_q == '0) ? LFSR_SEED : a_q;
        alu_res_c = lfsr_nx_c;
      end
      OPC_MUTE: begin
        lfsr_nx_c = lfsr_step_c;
        alu_res_c = sat(wide(a_q) + wide(mute_sh_c));
      end
      default: begin
        alu_res_c = a_q;
        alu_ill_c = 1'b1;
      end
    endcase
  end

  // Control FSM; DONE commits result, accumulator and LFSR on its exit edge.
  always_comb begin
    state_d    = state_q;
    start_d    = start;
    opc_d      = opc_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    lfsr_d     = lfsr_q;
    result_d   = result_q;
    finished_d = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          opc_d   = instr_c.opc;
          a_d     = instr_c.a;
          b_d     = instr_c.b;
          state_d = is_mult_c ? ST_MULT : ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_MULT: if (mult_done) state_d = ST_DONE;
      ST_DONE: begin
        state_d    = ST_IDLE;
        result_d   = alu_res_c;
        finished_d = 1'b1;
        illegal_d  = alu_ill_c;
        acc_d      = acc_nx_c;
        lfsr_d     = lfsr_nx_c;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) || finished_d;
  end

  assign result   = result_q;
  assign finished = finished_q;
  assign busy     = busy_q;
  assign illegal  = illegal_q;

endmodule
